// File: rtl/u_div_pkg.sv
// u_div_pkg: shared types and constants for the sequential restoring divider.
//   div_state_e : controller states (idle, iterating, result held)
//   DIV_N       : default divisor/quotient/remainder width (dividend is 2*DIV_N)
//   DIV_CNT_W   : width of the step counter for the default width
//   DIV_SAT     : saturated quotient returned for zero-divisor and overflow
package u_div_pkg;

    localparam int unsigned DIV_N     = 8;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_N);
    localparam logic [DIV_N-1:0] DIV_SAT = {DIV_N{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_e;

endpackage

// File: rtl/u_div_step.sv
// u_div_step: one combinational restoring-division cell.
// Forms trial = {i_pr, i_bit} - {1'b0, i_b} with an (N+1)-bit ripple of full-adder
// cells (minuend + inverted subtrahend + carry-in 1), then selects between the
// trial difference and the plain shifted remainder.
//   i_pr   : partial remainder (always < i_b on entry)
//   i_bit  : next dividend bit shifted into the remainder
//   i_b    : divisor
//   o_pr   : updated partial remainder
//   o_qbit : quotient bit (1 when the trial subtraction did not borrow)
module u_div_step #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_pr,
    input  logic         i_bit,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_pr,
    output logic         o_qbit
);

    logic [N:0]   w_min;
    logic [N:0]   w_sub_n;
    logic [N-1:0] w_diff;
    logic [N+1:0] w_carry;

    assign w_min      = {i_pr, i_bit};
    assign w_sub_n    = ~{1'b0, i_b};
    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi < N; gi++) begin : g_fa
        assign w_diff[gi]    = w_min[gi] ^ w_sub_n[gi] ^ w_carry[gi];
        assign w_carry[gi+1] = (w_min[gi] & w_sub_n[gi]) | (w_min[gi] & w_carry[gi]) |
                               (w_sub_n[gi] & w_carry[gi]);
    end

    // Only the carry of the top cell matters: the difference fits in N bits
    // whenever it is non-negative because i_pr < i_b.
    assign w_carry[N+1] = (w_min[N] & w_sub_n[N]) | (w_min[N] & w_carry[N]) |
                          (w_sub_n[N] & w_carry[N]);

    // Carry out of a subtraction done as addition means no borrow.
    assign o_qbit = w_carry[N+1];
    assign o_pr   = o_qbit ? w_diff : w_min[N-1:0];

endmodule

// File: rtl/u_seqdiv8.sv
// u_seqdiv8: iterative unsigned restoring divider, 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, valid/ready handshake on operands and result.
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   : operand handshake; in_ready is high only when idle
//   a, b                  : dividend (2N bits) and divisor (N bits), sampled on accept
//   out_valid / out_ready : result handshake; result held until consumed
//   quot, rem             : quotient and remainder (held until the next result)
//   div_by_zero           : b was zero (quot saturated, rem = low half of a)
//   overflow              : true quotient exceeds N bits (quot saturated, rem = 0)
module u_seqdiv8
    import u_div_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quot,
    output logic [N-1:0]   rem,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] Sat = {N{1'b1}};
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    div_state_e      r_state, w_state_nxt;
    logic [N-1:0]    r_pr, w_pr_nxt;
    logic [N-1:0]    r_sh, w_sh_nxt;
    logic [N-1:0]    r_b, w_b_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0]    r_quot, w_quot_nxt;
    logic [N-1:0]    r_rem, w_rem_nxt;
    logic            r_dbz, w_dbz_nxt;
    logic            r_ovf, w_ovf_nxt;

    logic [N-1:0]    w_step_pr;
    logic            w_step_qbit;
    logic [N-1:0]    w_sh_shift;

    u_div_step #(
        .N (N)
    ) u_step (
        .i_pr   (r_pr),
        .i_bit  (r_sh[N-1]),
        .i_b    (r_b),
        .o_pr   (w_step_pr),
        .o_qbit (w_step_qbit)
    );

    // The dividend low half drains out of the top of r_sh while quotient bits
    // fill in from the bottom.
    assign w_sh_shift = {r_sh[N-2:0], w_step_qbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_pr    <= '0;
            r_sh    <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pr    <= w_pr_nxt;
            r_sh    <= w_sh_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dbz   <= w_dbz_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pr_nxt    = r_pr;
        w_sh_nxt    = r_sh;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dbz_nxt   = r_dbz;
        w_ovf_nxt   = r_ovf;

        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    if (b == '0) begin
                        w_state_nxt = StDone;
                        w_dbz_nxt   = 1'b1;
                        w_ovf_nxt   = 1'b0;
                        w_quot_nxt  = Sat;
                        w_rem_nxt   = a[N-1:0];
                    end else if (a[2*N-1:N] >= b) begin
                        // High half already >= divisor: quotient needs more than N bits.
                        w_state_nxt = StDone;
                        w_dbz_nxt   = 1'b0;
                        w_ovf_nxt   = 1'b1;
                        w_quot_nxt  = Sat;
                        w_rem_nxt   = '0;
                    end else begin
                        w_state_nxt = StCalc;
                        w_pr_nxt    = a[2*N-1:N];
                        w_sh_nxt    = a[N-1:0];
                        w_b_nxt     = b;
                        w_cnt_nxt   = CntLast;
                        w_dbz_nxt   = 1'b0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
            end
            StCalc: begin
                w_pr_nxt = w_step_pr;
                w_sh_nxt = w_sh_shift;
                if (r_cnt == '0) begin
                    w_state_nxt = StDone;
                    w_quot_nxt  = w_sh_shift;
                    w_rem_nxt   = w_step_pr;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign in_ready    = (r_state == StIdle);
    assign out_valid   = (r_state == StDone);
    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_u_seqdiv8.sv
module tb_u_seqdiv8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        div_by_zero;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    u_seqdiv8 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden model written as plain integer arithmetic plus the flag rules.
    function automatic void model(input logic [15:0] ma, input logic [7:0] mb,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z, output logic o);
        logic [15:0] wide_b;
        wide_b = {8'h00, mb};
        if (mb == 8'h00) begin
            q = 8'hFF; r = ma[7:0]; z = 1'b1; o = 1'b0;
        end else if (ma[15:8] >= mb) begin
            q = 8'hFF; r = 8'h00; z = 1'b0; o = 1'b1;
        end else begin
            q = 8'(ma / wide_b); r = 8'(ma % wide_b); z = 1'b0; o = 1'b0;
        end
    endfunction

    // Runs one operation from the idle state; hold = cycles of result backpressure.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [7:0] tb,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input logic eo, input int elat, input int hold);
        int cyc;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        a         = ta;
        b         = tb;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        // Operands must have been sampled on the accept edge only.
        a = 16'($urandom);
        b = 8'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
            tick();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(elat));
        check({tag, " quot"}, 32'(quot), 32'(eq));
        check({tag, " rem"}, 32'(rem), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
        check({tag, " overflow"}, 32'(overflow), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold quot"}, 32'(quot), 32'(eq));
            check({tag, " hold rem"}, 32'(rem), 32'(er));
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " consumed out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " consumed in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " quot kept"}, 32'(quot), 32'(eq));
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [7:0]  mq, mr;
        logic        mz, mo;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quot", 32'(quot), 32'd0);
        check("reset rem", 32'(rem), 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        run_op("basic 1000/7", 16'h03E8, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 8, 0);
        run_op("max FE01/FF", 16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8, 0);
        run_op("max 00FF/01", 16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 8, 0);
        run_op("ovf FFFF/FF", 16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 0, 0);
        run_op("dbz 1234/0", 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 0, 0);
        run_op("ovf 0700/07", 16'h0700, 8'h07, 8'hFF, 8'h00, 1'b0, 1'b1, 0, 0);
        run_op("bp 100/9", 16'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b0, 8, 5);

        // Reset during the third CALC step discards the operation.
        a        = 16'hABCD;
        b        = 8'hEF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid-calc busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid-calc rst out_valid", 32'(out_valid), 32'd0);
        check("mid-calc rst quot", 32'(quot), 32'd0);
        check("mid-calc rst rem", 32'(rem), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op("after rst 50/5", 16'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0, 8, 0);

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            if (i % 17 == 0) rb = 8'h00;
            else if (i % 5 == 0) rb = ra[15:8] - 8'(i % 3);
            model(ra, rb, mq, mr, mz, mo);
            run_op("random", ra, rb, mq, mr, mz, mo, (mz || mo) ? 0 : 8, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
